// File: rtl/ysyx_24070014_dmem_responder_pkg.sv
// Purpose: shared widths, base address and FSM encoding for the data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_24070014_dmem_responder_pkg;

    localparam int WORD_LEN = 32;
    localparam int STRB_W   = WORD_LEN / 8;

    // Reset PC of the core; also the byte address that maps to word 0 of the store.
    localparam logic [WORD_LEN-1:0] INIT_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte offset of an address from the base of the backing store (modulo 2^32).
    function automatic logic [WORD_LEN-1:0] byte_offset(input logic [WORD_LEN-1:0] addr,
                                                       input logic [WORD_LEN-1:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/ysyx_24070014_dmem_responder_if.sv
// Purpose: request/response bundle between core LSU (master) and memory responder (slave).
// Latency: n/a (wires only). resp_err exists only with ysyx_24070014_DMEM_RANGE_CHECK_EN.
// Backpressure: valid/ready on both the request and the response channel.
interface ysyx_24070014_dmem_responder_if
    import ysyx_24070014_dmem_responder_pkg::*;
();

    logic                req_valid;
    logic                req_ready;
    logic [WORD_LEN-1:0] req_addr;
    logic                req_wen;
    logic [WORD_LEN-1:0] req_wdata;
    logic [STRB_W-1:0]   req_wstrb;
    logic                resp_valid;
    logic                resp_ready;
    logic [WORD_LEN-1:0] resp_rdata;
`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
    logic                resp_err;
`endif

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata
`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
        , input resp_err
`endif
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata
`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
        , output resp_err
`endif
    );

endinterface

// File: rtl/ysyx_24070014_sram_1rw.sv
// Purpose: single-port synchronous word RAM with per-byte write enables; contents never reset.
// Latency: write and read both take effect on the enabled edge; read data is registered and held.
// Backpressure: none; the owner decides when to enable an access.
module ysyx_24070014_sram_1rw
    import ysyx_24070014_dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic                i_wen,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [WORD_LEN-1:0] i_wdata,
    input  logic [STRB_W-1:0]   i_wstrb,
    output logic [WORD_LEN-1:0] o_rdata
);

    logic [WORD_LEN-1:0] r_mem [0:(1 << ADDR_W) - 1];
    logic [WORD_LEN-1:0] r_rdata;

    // One access per enabled edge: strobed byte write, or a read captured into the output register.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_wen) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (i_wstrb[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_24070014_dmem_responder.sv
// Purpose: data-memory responder, one outstanding load/store into a byte-strobed word RAM.
// Latency: accept-to-resp_valid is exactly LATENCY (1..15) cycles; macro ysyx_24070014_DMEM_RANGE_CHECK_EN adds resp_err.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready, no same-cycle turnaround.
module ysyx_24070014_dmem_responder
    import ysyx_24070014_dmem_responder_pkg::*;
#(
    parameter int                  DEPTH_LOG2 = 10,
    parameter logic [WORD_LEN-1:0] BASE_ADDR  = INIT_PC,
    parameter int                  LATENCY    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    ysyx_24070014_dmem_responder_if.slave  bus
);

    // With LATENCY==1 the RAM access happens on the accept edge itself, straight from the bus.
    localparam bit         ZERO_WAIT = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [WORD_LEN-1:0] r_addr, r_wdata;
    logic                r_wen;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_err;

    logic                w_req_ready, w_resp_valid;
    logic                w_access, w_live, w_err;
    logic [WORD_LEN-1:0] w_a_addr, w_a_wdata, w_off;
    logic                w_a_wen;
    logic [STRB_W-1:0]   w_a_wstrb;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [WORD_LEN-1:0] w_sram_rdata;

    // Access edge: last WAIT cycle (counter about to hit 0), or the accept edge when there is no wait.
    assign w_access = (r_state == ST_WAIT && r_cnt == 4'd1) ||
                      (ZERO_WAIT && r_state == ST_IDLE && bus.req_valid);

    // In IDLE the only possible access is the zero-wait one, which must use the live request.
    assign w_live    = (r_state == ST_IDLE);
    assign w_a_addr  = w_live ? bus.req_addr  : r_addr;
    assign w_a_wen   = w_live ? bus.req_wen   : r_wen;
    assign w_a_wdata = w_live ? bus.req_wdata : r_wdata;
    assign w_a_wstrb = w_live ? bus.req_wstrb : r_wstrb;

    assign w_off   = byte_offset(w_a_addr, BASE_ADDR);
    assign w_index = DEPTH_LOG2'(w_off >> 2);

`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
    assign w_err = ((w_off >> (DEPTH_LOG2 + 2)) != '0);
`else
    assign w_err = 1'b0;
`endif

    // Reset on the access edge suppresses the write so a dropped store never lands.
    ysyx_24070014_sram_1rw #(
        .ADDR_W (DEPTH_LOG2)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_access && !reset),
        .i_wen   (w_a_wen && !w_err),
        .i_addr  (w_index),
        .i_wdata (w_a_wdata),
        .i_wstrb (w_a_wstrb),
        .o_rdata (w_sram_rdata)
    );

    // Next-state and handshake outputs for the IDLE -> WAIT -> RESP -> IDLE sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (ZERO_WAIT) begin
                        w_state_nxt = ST_RESP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, wait counter, request latches and the error flag captured on the access edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_req_ready && bus.req_valid) begin
                r_addr  <= bus.req_addr;
                r_wen   <= bus.req_wen;
                r_wdata <= bus.req_wdata;
                r_wstrb <= bus.req_wstrb;
            end
            if (w_access) begin
                r_err <= w_err;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    // RAM read register holds across the RESP stall; stores and errors report zero data.
    assign bus.resp_rdata = (r_state == ST_RESP && !r_wen && !r_err) ? w_sram_rdata : '0;
`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
    assign bus.resp_err   = (r_state == ST_RESP) && r_err;
`endif

endmodule

// File: tb/tb_ysyx_24070014_dmem_responder.sv
// Purpose: scoreboard bench for the data-memory responder (LATENCY=2 main instance, LATENCY=1 side instance).
// Latency: expects resp_valid exactly LATENCY cycles after each accepted request.
// Backpressure: exercises resp_ready stalls, requests while busy and reset during WAIT.
module tb_ysyx_24070014_dmem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ysyx_24070014_dmem_responder_if bus ();
    ysyx_24070014_dmem_responder_if bus1 ();

    ysyx_24070014_dmem_responder #(
        .DEPTH_LOG2 (10),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ysyx_24070014_dmem_responder #(
        .DEPTH_LOG2 (10),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 1'b0;

`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
    localparam logic [31:0] WRAP_RD    = 32'h0000_0000;
    localparam logic        WRAP_ERR   = 1'b1;
    localparam logic [31:0] MEM0_AFTER = 32'h1234_5678;
`else
    localparam logic [31:0] WRAP_RD    = 32'h1234_5678;
    localparam logic        WRAP_ERR   = 1'b0;
    localparam logic [31:0] MEM0_AFTER = 32'hFFFF_FFFF;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: required event did not occur (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: track accepts, pop the scoreboard on each new response, check every RESP cycle.
    always @(negedge clk) begin
        if (reset) begin
            have_cur = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
            if (bus.resp_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        chk("latency", 32'(cyc - acc_cyc), 32'(LAT));
                    end
                end
                if (have_cur) begin
                    chk("resp_rdata", bus.resp_rdata, cur.rdata);
`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, cur.err});
`endif
                    chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
                    if (bus.resp_ready) begin
                        have_cur = 1'b0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) fail_now("accept_timeout");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == d0) fail_now("response_timeout");
    endtask

    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic ee);
        int d0;
        d0 = done_cnt;
        exp_q.push_back('{er, ee});
        issue(a, w, d, s);
        wait_done(d0);
    endtask

    // Load held off by resp_ready for several cycles while a store request sits on the bus.
    task automatic txn_stall(input logic [31:0] a, input logic [31:0] er,
                             input logic [31:0] ia, input logic [31:0] id, input int stall);
        int d0;
        int n;
        d0 = done_cnt;
        exp_q.push_back('{er, 1'b0});
        bus.resp_ready = 1'b0;
        issue(a, 1'b0, 32'd0, 4'h0);
        bus.req_valid = 1'b1;
        bus.req_addr  = ia;
        bus.req_wen   = 1'b1;
        bus.req_wdata = id;
        bus.req_wstrb = 4'hF;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        wait_done(d0);
        bus.req_valid = 1'b0;
    endtask

    // LATENCY=1 instance: response must be visible in the cycle right after the accept.
    task automatic txn1(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er);
        @(posedge clk); #1;
        bus1.req_valid = 1'b1;
        bus1.req_addr  = a;
        bus1.req_wen   = w;
        bus1.req_wdata = d;
        bus1.req_wstrb = s;
        @(negedge clk);
        chk("l1_req_ready", {31'd0, bus1.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        @(negedge clk);
        chk("l1_resp_valid", {31'd0, bus1.resp_valid}, 32'd1);
        chk("l1_resp_rdata", bus1.resp_rdata, er);
        @(negedge clk);
        chk("l1_resp_done", {31'd0, bus1.resp_valid}, 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wen    = 1'b0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.resp_ready = 1'b1;
        bus1.req_valid  = 1'b0;
        bus1.req_addr   = '0;
        bus1.req_wen    = 1'b0;
        bus1.req_wdata  = '0;
        bus1.req_wstrb  = '0;
        bus1.resp_ready = 1'b1;

        // Reset state and quiet idle.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
`ifdef ysyx_24070014_DMEM_RANGE_CHECK_EN
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("idle_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        end

        // Full-word store then load.
        txn(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        txn(32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte strobes: lane 0, no lanes, upper two lanes.
        txn(32'h8000_0010, 1'b1, 32'h0000_00AA, 4'h1, 32'h0, 1'b0);
        txn(32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);
        txn(32'h8000_0010, 1'b1, 32'h1122_3344, 4'h0, 32'h0, 1'b0);
        txn(32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);
        txn(32'h8000_0012, 1'b1, 32'h5566_0000, 4'hC, 32'h0, 1'b0);
        txn(32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'h5566_BEAA, 1'b0);

        // Response stall with a store request pending on the bus; that store must be ignored.
        txn(32'h8000_0020, 1'b1, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
        txn_stall(32'h8000_0010, 32'h5566_BEAA, 32'h8000_0020, 32'hCAFE_F00D, 5);
        txn(32'h8000_0020, 1'b0, 32'h0,         4'h0, 32'h0102_0304, 1'b0);

        // One past the top of the 4 KiB store: wraps to word 0, or flags an error.
        txn(32'h8000_0000, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        txn(32'h8000_1000, 1'b0, 32'h0,         4'h0, WRAP_RD, WRAP_ERR);
        txn(32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, WRAP_ERR);
        txn(32'h8000_0000, 1'b0, 32'h0,         4'h0, MEM0_AFTER, 1'b0);

        // Reset during WAIT of a store: back to IDLE, no response, no write.
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0010;
        bus.req_wen   = 1'b1;
        bus.req_wdata = 32'hA5A5_A5A5;
        bus.req_wstrb = 4'hF;
        @(negedge clk);
        chk("pre_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h5566_BEAA, 1'b0);

        // LATENCY=1 instance.
        txn1(32'h8000_0040, 1'b1, 32'h0BAD_CAFE, 4'hF, 32'h0);
        txn1(32'h8000_0040, 1'b0, 32'h0,         4'h0, 32'h0BAD_CAFE);

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) fail_now("scoreboard_drained");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
